// File: rtl/router_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo_if
// Description : Handshake bundle between the router write/read side and one
//               output-port packet FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface router_fifo_if;
  logic [7:0] data_in;
  logic       write_enb;
  logic       lfd_state;
  logic       read_enb;
  logic       soft_reset;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  // Router side: drives write/read requests and flush, observes data and flags
  modport master (
    output data_in, write_enb, lfd_state, read_enb, soft_reset,
    input  data_out, full, empty
  );

  // FIFO side
  modport slave (
    input  data_in, write_enb, lfd_state, read_enb, soft_reset,
    output data_out, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo
// Description : 16 x 9 packet-buffer FIFO for one output port of a 1x3 router.
//               Bit 8 of each word marks a packet header. The header's length
//               field loads a packet counter so that data_out returns to its
//               idle value once header, payload and parity have been read.
//               Optional macro ROUTER_FIFO_HIZ_EN: idle value of data_out is
//               8'bz instead of 8'h00 (reset always drives 8'h00).
// Revision    : 1.0 - initial release
// ============================================================================
module router_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  wire logic        clock,
  input  wire logic        resetn,
  router_fifo_if.slave     bus
);

  localparam int ADDR_W = PTR_W - 1;

`ifdef ROUTER_FIFO_HIZ_EN
  localparam logic [7:0] c_IDLE_BYTE = 8'bz;
`else
  localparam logic [7:0] c_IDLE_BYTE = 8'h00;
`endif

  // Storage and pointers
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [5:0]       pkt_count_q, pkt_count_d;
  logic [7:0]       data_out_q, data_out_d;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [WIDTH-1:0] w_rd_word;

  // Occupancy flags: equal pointers mean empty, equal index with differing
  // wrap bit means the writer has lapped the reader (full).
  always_comb begin
    w_empty = (wr_ptr_q == rd_ptr_q);
    w_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
              (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  end

  // Qualified requests; flags are taken from the pre-edge state so a read on
  // a full FIFO never lets a same-cycle write through, and a write on an
  // empty FIFO never falls through to the output.
  always_comb begin
    w_wr_ok   = bus.write_enb && !w_full;
    w_rd_ok   = bus.read_enb  && !w_empty;
    w_rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  // Next-state for pointers, packet counter and output byte
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    data_out_d  = data_out_q;

    if (w_wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (w_rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = w_rd_word[7:0];
      if (w_rd_word[WIDTH-1]) begin
        // Header: length field (bits 7:2) plus one parity byte still to come
        pkt_count_d = w_rd_word[7:2] + 6'd1;
      end else if (pkt_count_q != 6'd0) begin
        pkt_count_d = pkt_count_q - 6'd1;
      end
    end else if (pkt_count_q == 6'd0) begin
      // Whole packet consumed and nothing new read: release the bus
      data_out_d = c_IDLE_BYTE;
    end
  end

  // State registers and memory with reset > flush > normal priority
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      data_out_q  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.soft_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      data_out_q  <= c_IDLE_BYTE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      data_out_q  <= data_out_d;
      if (w_wr_ok) begin
        mem_q[wr_ptr_q[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_fifo
// Description : Self-checking bench for router_fifo. A queue-based model of
//               the packet FIFO predicts data_out, empty and full each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fifo;

`ifdef ROUTER_FIFO_HIZ_EN
  localparam logic [7:0] c_IDLE = 8'bz;
`else
  localparam logic [7:0] c_IDLE = 8'h00;
`endif

  logic clock;
  logic resetn;

  router_fifo_if bus ();

  router_fifo dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [8:0] m_q [$];
  int         m_cnt;
  logic [7:0] m_dout;

  int n_assert;
  int n_fail;

  // Model of one rising edge using the inputs currently applied
  task automatic model_edge();
    bit         can_rd;
    bit         can_wr;
    logic [8:0] w;
    if (!resetn) begin
      m_q.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
    end else if (bus.soft_reset) begin
      m_q.delete();
      m_cnt  = 0;
      m_dout = c_IDLE;
    end else begin
      can_rd = bus.read_enb  && (m_q.size() != 0);
      can_wr = bus.write_enb && (m_q.size() < 16);
      if (can_rd) begin
        w      = m_q.pop_front();
        m_dout = w[7:0];
        if (w[8])          m_cnt = (int'(w[7:2]) + 1) % 64;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = c_IDLE;
      end
      if (can_wr) m_q.push_back({bus.lfd_state, bus.data_in});
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: advance DUT and model, then compare outputs 1 time unit later
  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    chk({tag, ".data_out"}, bus.data_out, m_dout);
    chk({tag, ".empty"}, {7'd0, bus.empty}, {7'd0, m_q.size() == 0});
    chk({tag, ".full"},  {7'd0, bus.full},  {7'd0, m_q.size() == 16});
  endtask

  task automatic drive(input bit wr, input bit rd, input bit lfd, input logic [7:0] d);
    bus.write_enb = wr;
    bus.read_enb  = rd;
    bus.lfd_state = lfd;
    bus.data_in   = d;
  endtask

  initial begin
    logic [7:0] par;
    logic [7:0] b;
    n_assert = 0;
    n_fail   = 0;
    m_cnt    = 0;
    m_dout   = 8'h00;
    resetn          = 1'b0;
    bus.soft_reset  = 1'b0;
    drive(0, 0, 0, 8'h00);

    // Reset then flush
    tick("reset");
    chk("reset.dout_zero", bus.data_out, 8'h00);
    resetn = 1'b1;
    bus.soft_reset = 1'b1;
    tick("soft_reset");
    bus.soft_reset = 1'b0;

    // Full packet: header 0x39, 14 payload, parity
    drive(1, 0, 1, 8'h39);
    par = 8'h39;
    tick("wr_hdr");
    chk("wr_hdr.not_empty", {7'd0, bus.empty}, 8'h00);
    for (int i = 0; i < 15; i++) begin
      b = (i == 14) ? par : 8'($urandom);
      par = par ^ b;
      drive(1, 0, 0, b);
      tick("wr_payload");
    end
    chk("wr16.full", {7'd0, bus.full}, 8'h01);
    drive(1, 0, 0, 8'hAA);
    tick("wr_drop");

    // Readback of the whole packet, then idle
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) tick("rd_pkt");
    chk("rd16.empty", {7'd0, bus.empty}, 8'h01);
    tick("rd_after_empty");
    chk("rd_idle", bus.data_out, c_IDLE);

    // Advance pointers so the simultaneous phase crosses entry 15
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 8'($urandom));
      tick("fill12");
    end
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) tick("drain12");

    // Four words stored, then 8 edges of simultaneous read/write
    drive(1, 0, 1, 8'h1C);
    tick("sim_hdr");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 8'($urandom));
      tick("sim_pre");
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 8'($urandom));
      tick("sim_rw");
    end
    chk("sim.occupancy4", 8'(m_q.size()), 8'd4);
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < 6; i++) tick("sim_drain");

    // Read while empty: nothing changes
    b = bus.data_out;
    for (int i = 0; i < 3; i++) tick("empty_rd");
    chk("empty_rd.hold", bus.data_out, b);

    // Mid-packet flush: header length 5, read header + 2 payload, then flush
    drive(1, 0, 1, 8'h15);
    tick("mf_hdr");
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 8'($urandom));
      tick("mf_wr");
    end
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) tick("mf_rd");
    drive(0, 0, 0, 8'h00);
    bus.soft_reset = 1'b1;
    tick("mf_flush");
    bus.soft_reset = 1'b0;
    chk("mf_flush.idle", bus.data_out, c_IDLE);

    // New packet header 0x08 (length 2) + 2 payload + parity
    drive(1, 0, 1, 8'h08);
    tick("np_hdr");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 8'($urandom));
      tick("np_wr");
    end
    drive(0, 1, 0, 8'h00);
    tick("np_rd_hdr");
    chk("np_rd_hdr.val", bus.data_out, 8'h08);
    for (int i = 0; i < 3; i++) tick("np_rd");
    tick("np_idle");
    chk("np_idle.val", bus.data_out, c_IDLE);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom));
      bus.soft_reset = ($urandom_range(0, 63) == 0);
      tick("rand");
    end
    bus.soft_reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Packet-buffer FIFO for one output port of a 1x3 router: 16 entries, each 9 bits wide (an 8-bit byte plus a header-marker bit).
- Written by the router's synchroniser/FSM side and read by the destination port.
- Tracks packet length from the header so `data_out` is released to idle once the whole packet (header, payload, parity) has been read.

Parameters:
- WIDTH, 9, stored word width: bit 8 = header marker (lfd), bits 7:0 = data byte.
- DEPTH, 16, number of entries; must be a power of 2.
- PTR_W, 5, pointer width = log2(DEPTH)+1; the MSB is the wrap bit.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- data_in  in  8  byte to write.
- read_enb  in  1  read request.
- write_enb  in  1  write request.
- data_out  out  8  registered read data.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- lfd_state  in  1  high when data_in is a packet header; stored as bit 8.
- soft_reset  in  1  synchronous flush (timeout from router control).

Behaviour:
- Interface: one clock (clock); reset (resetn) is synchronous, active-low.
- Priority each edge: resetn low > soft_reset high > normal operation.
- resetn=0:
  - wr_ptr, rd_ptr and pkt_count = 0.
  - All memory words cleared to 0.
  - data_out = 8'h00.
- soft_reset=1 (resetn=1):
  - Pointers, pkt_count and memory cleared.
  - data_out = idle value (see Optional Feature).
  - Writes and reads in that cycle are ignored.
- Write:
  - When write_enb=1 and full=0: mem[wr_ptr[3:0]] <= {lfd_state, data_in}; wr_ptr++.
  - When full=1, the write is dropped and no state changes.
- Read:
  - When read_enb=1 and empty=0: data_out <= mem[rd_ptr[3:0]][7:0]; rd_ptr++.
  - Latency: data appears one clock after the read edge.
  - read_enb when empty=1 is ignored; data_out holds its value.
- Packet counter pkt_count (6 bits):
  - If the word read has bit 8 = 1: pkt_count <= word[7:2] + 1 (payload length + parity byte).
  - Otherwise, on each successful read with pkt_count != 0: pkt_count--.
  - On an edge with no successful read and pkt_count == 0: data_out <= idle value.
  - Otherwise data_out holds.
- Flags (combinational from pointers):
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[4] != rd_ptr[4]) && (wr_ptr[3:0] == rd_ptr[3:0]).
- Simultaneous read and write:
  - When neither full nor empty, both occur in the same cycle; occupancy is unchanged.
  - When full, only the read occurs; the write is blocked even though a slot frees that edge.
  - When empty, only the write occurs; no fall-through.
- Wrap-around: pointers increment modulo 32; the index is ptr[3:0], so the entry after 15 is 0.
- Reset or soft_reset mid-packet discards all stored words and the remaining count; the next read sequence must begin with a header.

Optional Feature:
- Macro: ROUTER_FIFO_HIZ_EN.
- Defined: the idle value of data_out (after soft_reset, and on pkt_count==0 with no read) is high-impedance 8'bz.
- Undefined: the idle value is 8'h00, for synthesis flows without internal tristates.
- resetn always drives 8'h00 regardless of the macro.

Test Plan:
- Reset: resetn=0 for one edge -> data_out=8'h00, empty=1, full=0. Then soft_reset=1 for one edge -> empty=1, data_out=idle value (Z with ROUTER_FIFO_HIZ_EN).
- Full packet write:
  - Header 8'h39 (length 14, addr 01) with lfd_state=1, then 14 random payload bytes and 1 parity byte with lfd_state=0, write_enb=1 on consecutive edges.
  - Expected: empty=0 after the first edge; full=1 after the 16th write.
  - A 17th write of 8'hAA is dropped and is never read back.
- Readback:
  - After the packet above, set write_enb=0 and read_enb=1.
  - Expected: data_out=8'h39 one clock after the first read edge, then the 14 payload bytes and parity in order.
  - empty=1 after the 16th read.
  - One edge later data_out = idle value.
- Simultaneous read/write: with 4 words stored, assert read_enb and write_enb for 8 edges -> occupancy stays 4, data is in order, and pointers wrap past entry 15 with correct data.
- Empty read: read_enb=1 while empty -> data_out unchanged, pointers unchanged, empty stays 1.
- Mid-packet flush: read a header of length 5 plus 2 payload bytes, then pulse soft_reset -> empty=1, data_out=idle. A new packet with header 8'h08 (length 2) reads back correctly: after 3 more reads, data_out goes idle.
